// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Core request/response and SRAM bus bundle for mem_access_unit.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // master: the access unit itself; slave: the core plus SRAM around it
    modport master (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_enable, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store master for a byte-addressed 32-bit SRAM; sub-word
//               stores are read-modify-write. Optional MAU_ALIGN_CHECK_EN
//               rejects misaligned half/word accesses.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 32,
    parameter int unsigned MEM_LIMIT = 65532
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_access_unit_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t            r_state;
    logic              r_wr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_merged;
    logic [DATA_W-1:0] r_rdata;

    logic              w_reject;
    logic [DATA_W-1:0] w_load_ext;
    logic [DATA_W-1:0] w_merge;

    always_comb begin
        w_reject = (bus.req_size == 2'b11) ||
                   ({{(32-ADDR_W){1'b0}}, bus.req_addr} >= MEM_LIMIT);
`ifdef MAU_ALIGN_CHECK_EN
        if (bus.req_size == 2'b01 && bus.req_addr[0])
            w_reject = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
            w_reject = 1'b1;
`endif
    end

    always_comb begin
        w_load_ext = bus.mem_rdata;
        case (r_size)
            2'b00:   w_load_ext = {{24{~r_uns & bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
            2'b01:   w_load_ext = {{16{~r_uns & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            default: w_load_ext = bus.mem_rdata;
        endcase
    end

    // r_merged holds the store data until RMW_RD folds it into the read word
    always_comb begin
        w_merge = bus.mem_rdata;
        case (r_size)
            2'b00:   w_merge = {bus.mem_rdata[31:8],  r_merged[7:0]};
            2'b01:   w_merge = {bus.mem_rdata[31:16], r_merged[15:0]};
            default: w_merge = r_merged;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wr     <= 1'b0;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_addr   <= '0;
            r_merged <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_wr     <= bus.req_wr;
                        r_size   <= bus.req_size;
                        r_uns    <= bus.req_unsigned;
                        r_addr   <= bus.req_addr;
                        r_merged <= bus.req_wdata;
                        r_rdata  <= '0;
                        if (w_reject)
                            r_state <= ERR;
                        else if (!bus.req_wr)
                            r_state <= READ;
                        else if (bus.req_size == 2'b10)
                            r_state <= WRITE;
                        else
                            r_state <= RMW_RD;
                    end
                end
                READ: begin
                    r_rdata <= w_load_ext;
                    r_state <= RESP;
                end
                RMW_RD: begin
                    r_merged <= w_merge;
                    r_state  <= WRITE;
                end
                WRITE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes come straight off the state register so reset kills them at once
    logic w_mem_active;
    assign w_mem_active   = (r_state == READ) || (r_state == RMW_RD) || (r_state == WRITE);

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP) || (r_state == ERR);
    assign bus.resp_err   = (r_state == ERR);
    assign bus.resp_rdata = r_rdata;
    assign bus.mem_enable = w_mem_active;
    assign bus.mem_wr     = (r_state == WRITE);
    assign bus.mem_addr   = w_mem_active ? r_addr : '0;
    assign bus.mem_wdata  = (r_state == WRITE) ? r_merged : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a byte-array SRAM.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:65535];

    assign bus.mem_rdata = {mem[bus.mem_addr + 16'd3], mem[bus.mem_addr + 16'd2],
                            mem[bus.mem_addr + 16'd1], mem[bus.mem_addr]};

    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_wr) begin
            mem[bus.mem_addr]          <= bus.mem_wdata[7:0];
            mem[bus.mem_addr + 16'd1]  <= bus.mem_wdata[15:8];
            mem[bus.mem_addr + 16'd2]  <= bus.mem_wdata[23:16];
            mem[bus.mem_addr + 16'd3]  <= bus.mem_wdata[31:24];
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  lat;
        logic [7:0]  wrc;
        logic [7:0]  enc;
    } resp_t;

    resp_t exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        mem[a]         = d[7:0];
        mem[a + 16'd1] = d[15:8];
        mem[a + 16'd2] = d[23:16];
        mem[a + 16'd3] = d[31:24];
    endtask

    task automatic expect_resp(input logic err, input logic [31:0] rdata,
                               input int lat, input int wrc, input int enc);
        resp_t e;
        e.err = err; e.rdata = rdata; e.lat = 8'(lat); e.wrc = 8'(wrc); e.enc = 8'(enc);
        exp_q.push_back(e);
    endtask

    // Drives one request and records what the DUT did until its response
    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata, output resp_t o);
        o = '0;
        o.lat = 8'hFF;
        for (int i = 0; i < 10 && !bus.req_ready; i++) begin
            @(posedge clk); #1;
        end
        bus.req_wr = wr; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            o.enc += 8'(bus.mem_enable);
            o.wrc += 8'(bus.mem_wr);
            if (bus.resp_valid) begin
                o.err   = bus.resp_err;
                o.rdata = bus.resp_rdata;
                o.lat   = 8'(k);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        n_cmp++; if (bus.req_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_err !== 1'b0)    begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
        n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
        n_cmp++; if (bus.mem_enable !== 1'b0)  begin n_bad++; $display("FAIL reset_mem_enable: got %b want 0", bus.mem_enable); end
        n_cmp++; if (bus.mem_wr !== 1'b0)      begin n_bad++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); end
        n_cmp++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_word;
        resp_t o, e;
        expect_resp(1'b0, 32'h0, 2, 1, 1);
        issue(1'b1, 2'b10, 1'b0, 16'h0100, 32'hDEADBEEF, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL word_store: got err=%b rdata=%h lat=%0d wr=%0d en=%0d want err=%b rdata=%h lat=%0d wr=%0d en=%0d",
                     o.err, o.rdata, o.lat, o.wrc, o.enc, e.err, e.rdata, e.lat, e.wrc, e.enc); end
        expect_resp(1'b0, 32'hDEADBEEF, 2, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL word_load: got err=%b rdata=%h lat=%0d wr=%0d en=%0d want err=%b rdata=%h lat=%0d wr=%0d en=%0d",
                     o.err, o.rdata, o.lat, o.wrc, o.enc, e.err, e.rdata, e.lat, e.wrc, e.enc); end
    endtask

    task automatic test_rmw;
        resp_t o, e;
        poke(16'h0100, 32'h11223344);
        poke(16'h0104, 32'h55667788);
        expect_resp(1'b0, 32'h0, 3, 1, 2);
        issue(1'b1, 2'b00, 1'b0, 16'h0101, 32'h000000AA, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL rmw_byte_store: got err=%b rdata=%h lat=%0d wr=%0d en=%0d want err=%b rdata=%h lat=%0d wr=%0d en=%0d",
                     o.err, o.rdata, o.lat, o.wrc, o.enc, e.err, e.rdata, e.lat, e.wrc, e.enc); end
        expect_resp(1'b0, 32'h1122AA44, 2, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL rmw_readback: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                     o.err, o.rdata, o.lat, e.err, e.rdata, e.lat); end
        // half store over the next word, low half replaced
        expect_resp(1'b0, 32'h0, 3, 1, 2);
        issue(1'b1, 2'b01, 1'b0, 16'h0104, 32'h1234BEEF, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL rmw_half_store: got err=%b lat=%0d wr=%0d en=%0d want err=%b lat=%0d wr=%0d en=%0d",
                     o.err, o.lat, o.wrc, o.enc, e.err, e.lat, e.wrc, e.enc); end
        n_cmp++; if ({mem[16'h0107], mem[16'h0106], mem[16'h0105], mem[16'h0104]} !== 32'h5566BEEF) begin n_bad++;
            $display("FAIL rmw_half_mem: got %h want 5566beef", {mem[16'h0107], mem[16'h0106], mem[16'h0105], mem[16'h0104]}); end
    endtask

    task automatic test_extend;
        logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exv [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0};
        resp_t o, e;
        poke(16'h0100, 32'h000080F0);
        for (int i = 0; i < 4; i++) begin
            expect_resp(1'b0, exv[i], 2, 0, 1);
            issue(1'b0, sz[i], un[i], 16'h0100, 32'h0, o);
            e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++;
                $display("FAIL extend_%0d: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                         i, o.err, o.rdata, o.lat, e.err, e.rdata, e.lat); end
        end
    endtask

    task automatic test_errors;
        resp_t o, e;
        poke(16'hFFFC, 32'hA5A5A5A5);
        poke(16'h0100, 32'h0BADF00D);
        expect_resp(1'b1, 32'h0, 1, 0, 0);
        issue(1'b1, 2'b10, 1'b0, 16'hFFFC, 32'h12345678, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL err_oob_store: got err=%b rdata=%h lat=%0d wr=%0d en=%0d want err=%b rdata=%h lat=%0d wr=%0d en=%0d",
                     o.err, o.rdata, o.lat, o.wrc, o.enc, e.err, e.rdata, e.lat, e.wrc, e.enc); end
        expect_resp(1'b1, 32'h0, 1, 0, 0);
        issue(1'b0, 2'b11, 1'b0, 16'h0100, 32'h0, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL err_size11: got err=%b rdata=%h lat=%0d en=%0d want err=%b rdata=%h lat=%0d en=%0d",
                     o.err, o.rdata, o.lat, o.enc, e.err, e.rdata, e.lat, e.enc); end
        n_cmp++; if ({mem[16'hFFFF], mem[16'hFFFE], mem[16'hFFFD], mem[16'hFFFC]} !== 32'hA5A5A5A5) begin n_bad++;
            $display("FAIL err_mem_unchanged: got %h want a5a5a5a5", {mem[16'hFFFF], mem[16'hFFFE], mem[16'hFFFD], mem[16'hFFFC]}); end
    endtask

    task automatic test_unaligned;
        resp_t o, e;
        poke(16'h0100, 32'h00000000);
        poke(16'h0104, 32'h00000000);
        poke(16'h0102, 32'h44332211);
`ifdef MAU_ALIGN_CHECK_EN
        expect_resp(1'b1, 32'h0, 1, 0, 0);
`else
        expect_resp(1'b0, 32'h44332211, 2, 0, 1);
`endif
        issue(1'b0, 2'b10, 1'b0, 16'h0102, 32'h0, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL unaligned_word: got err=%b rdata=%h lat=%0d en=%0d want err=%b rdata=%h lat=%0d en=%0d",
                     o.err, o.rdata, o.lat, o.enc, e.err, e.rdata, e.lat, e.enc); end
    endtask

    task automatic test_reset_mid_write;
        resp_t o, e;
        int seen;
        poke(16'h0100, 32'h55667788);
        for (int i = 0; i < 10 && !bus.req_ready; i++) begin
            @(posedge clk); #1;
        end
        bus.req_wr = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = 16'h0100; bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.mem_wr !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_write: got mem_wr=%b want 1", bus.mem_wr); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.mem_wr !== 1'b0)    begin n_bad++; $display("FAIL rstmid_mem_wr: got %b want 0", bus.mem_wr); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            seen += int'(bus.resp_valid);
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_no_resp: got %0d responses want 0", seen); end
        expect_resp(1'b0, 32'h55667788, 2, 0, 1);
        issue(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0, o);
        e = exp_q.pop_front();
        n_cmp++; if (o !== e) begin n_bad++;
            $display("FAIL rstmid_readback: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d",
                     o.err, o.rdata, o.lat, e.err, e.rdata, e.lat); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_word;
        test_rmw;
        test_extend;
        test_errors;
        test_unaligned;
        test_reset_mid_write;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side master for the byte-addressed 32-bit data SRAM.
- Turns core load/store requests (byte/half/word, signed/unsigned) into SRAM enable/wr/addr/data cycles.
- Sub-word stores are done as read-modify-write, because the SRAM always writes 4 bytes at addr..addr+3.
- Sits between the core's execute/memory stage and the SRAM; returns extended load data or an error response.

Parameters:
- ADDR_W, 16, byte address width to SRAM and core.
- DATA_W, 32, data width; fixed at 32, not to be overridden.
- MEM_LIMIT, 65532, first out-of-bounds byte address. Any addr >= MEM_LIMIT is rejected.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready at a clk edge.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  16  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: access rejected, no SRAM write occurred.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_enable  out  1  SRAM enable.
- mem_wr  out  1  SRAM write strobe.
- mem_addr  out  16  SRAM byte address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, combinational from mem_addr.

Behaviour:
- State machine states: IDLE, READ, RMW_RD, WRITE, RESP, ERR. Asynchronous rst forces IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- IDLE:
  - req_ready=1.
  - On acceptance, latch wr, size, unsigned, addr and wdata.
  - If size==11 or addr >= MEM_LIMIT -> ERR.
  - Else load -> READ; word store -> WRITE with merged=wdata; byte/half store -> RMW_RD.
- READ:
  - mem_enable=1, mem_addr=latched addr.
  - At the edge, capture mem_rdata into resp_rdata, extracted and extended per size/unsigned:
    - byte uses [7:0], extended from bit 7.
    - half uses [15:0], extended from bit 15.
    - word is taken as-is.
  - Next state RESP.
- RMW_RD:
  - mem_enable=1, mem_wr=0.
  - At the edge, merged = mem_rdata with low byte (size 00) or low half (size 01) replaced by wdata.
  - Next state WRITE.
- WRITE: mem_enable=1, mem_wr=1, mem_wdata=merged. The SRAM commits at this edge. Next state RESP.
- RESP: resp_valid=1, resp_err=0. resp_rdata holds the load value (0 for stores). Next state IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0. No mem_enable is asserted for the request. Next state IDLE.
- Latency from the acceptance edge to resp_valid high:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - error: 1 cycle.
- Throughput: one request in flight. req_ready is 0 in every state except IDLE. A new request may be accepted in the cycle after RESP/ERR.
- No response backpressure; the core must sample resp_valid.
- mem_enable/mem_wr are decoded from the registered state (glitch-free). Outside READ/RMW_RD/WRITE they are 0 and mem_wdata=0.
- Reset mid-operation: state returns to IDLE immediately and mem_wr drops asynchronously. A WRITE interrupted before its edge never commits, and no response is produced.
- Unaligned addresses inside bounds are legal by default; the SRAM is byte-addressed.

Optional Feature:
- Macro: MAU_ALIGN_CHECK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=00, goes to ERR (1-cycle error response, no SRAM access).
- Undefined: no alignment check; such accesses proceed normally.

Test Plan:
- Word store 0xDEADBEEF @0x0100, then word load @0x0100 -> mem_wr high exactly one cycle; resp_valid 2 cycles after each acceptance; load resp_rdata=0xDEADBEEF.
- Byte store 0x000000AA @0x0101 over word 0x11223344 @0x0100 -> RMW_RD then WRITE; word load @0x0100 returns 0x1122AA44.
- Loads @0x0100 holding 0x000080F0:
  - signed byte -> 0xFFFFFFF0.
  - unsigned byte -> 0x000000F0.
  - signed half -> 0xFFFF80F0.
  - unsigned half -> 0x000080F0.
- Store @0xFFFC and load with req_size=11 -> resp_err=1 one cycle after acceptance; mem_enable never asserted; memory unchanged.
- With MAU_ALIGN_CHECK_EN, word load @0x0102 -> resp_err=1. Without it -> resp_err=0, data = bytes 0x0102..0x0105.
- Assert rst while in WRITE, before the edge -> req_ready=1 and mem_wr=0 immediately; no resp_valid; target word unchanged on readback.
